gigatron_input_arbiter: RTL and testbench
=========================================

Name: gigatron_input_arbiter

Overview:
Owns the Gigatron's single serial controller input line (Famicom latch/pulse/data protocol) and shares it between two requesters: the live MiSTer joystick and a FIFO of injected bytes (typed text or key macros streamed from the HPS). It replaces the ad-hoc joypad shift register in the top level. It sequences each injected byte through hold and gap frames so the Gigatron ROM sees one clean keystroke per byte. Joystick activity always pre-empts injection.

Parameters:
FIFO_DEPTH, 16, injected-byte FIFO entries; power of two, at least 2.
HOLD_FRAMES, 2, latch frames each injected byte is presented; at least 1.
GAP_FRAMES, 2, latch frames of idle (0xFF) after each injected byte; at least 1.
CR_TO_LF, 1, if 1 an injected 0x0D is presented as 0x0A.

Ports:
clk_sys  input  1  system clock; all logic on the rising edge.
reset_n  input  1  asynchronous active-low reset.
joy_buttons  input  8  active-high buttons, NES order: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
famicom_latch  input  1  latch from the Gigatron, asynchronous to clk_sys.
famicom_pulse  input  1  shift clock from the Gigatron, asynchronous to clk_sys.
famicom_data  output  1  serial data to the Gigatron.
inj_valid  input  1  injected byte valid.
inj_data  input  8  injected byte.
inj_ready  output  1  FIFO can accept a byte.
flush  input  1  synchronous abort of all injection.
inj_busy  output  1  FIFO non-empty or state not IDLE.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: famicom_data=1, inj_ready=1, inj_busy=0, fifo_count=0. Shift register = 0xFF, state IDLE, counters 0, synchronizers 0.
- famicom_latch and famicom_pulse each pass through a 2-flop synchronizer, then an edge-detect register.
- Frame event: synchronized latch falling edge.
- Shift register (8 bits):
  - Loaded every cycle while synchronized latch is high with the selected value.
  - On each synchronized pulse falling edge (latch low) it shifts right with 1 filled into bit7.
  - If latch is high and a pulse falls in the same cycle, the load wins.
  - famicom_data = shift[0], registered. Latency from synchronizer input to data change is 3 clk_sys cycles.
- Joystick active: joy_buttons != 0.
- Selected value:
  - Joystick active: ~joy_buttons.
  - Otherwise in HOLD: char_reg.
  - Otherwise: 0xFF.
- FIFO:
  - Push when inj_valid && inj_ready.
  - inj_ready = (count < FIFO_DEPTH). Push is allowed in the same cycle as a pop only if not full at the start of that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - inj_data is never dropped while ready is high.
- State machine:
  - IDLE: if FIFO is non-empty and the joystick is not active, pop into char_reg (with CR_TO_LF translation), load hold_cnt=HOLD_FRAMES, go to HOLD.
  - HOLD: on a frame event with the joystick not active, decrement hold_cnt. When it reaches 0, load gap_cnt=GAP_FRAMES and go to GAP. Frame events while the joystick is active do not count; the byte is frozen, not lost.
  - GAP: on each frame event (joystick state irrelevant), decrement gap_cnt. When it reaches 0, go to IDLE.
- A byte of 0xFF is legal and presents as idle for its hold frames.
- flush (synchronous, highest priority after reset):
  - Empties the FIFO and forces IDLE.
  - Blocks the push in the same cycle.
  - The shift register is untouched; the next latch reloads it.
- Reset mid-frame: all state cleared immediately; famicom_data=1 asynchronously.

Test Plan:
- Reset then idle: reset_n low, then high, 5 latch/8-pulse frames, no input -> famicom_data reads 1 on all 8 bits of every frame; inj_ready=1, fifo_count=0.
- Joystick: joy_buttons=0x01 (A), one frame -> serial bits read LSB-first 0,1,1,1,1,1,1,1 (0xFE); 9th pulse and later read 1.
- Injection timing: push 0x41 then 0x0D with HOLD=2, GAP=2 -> frame sequence 0x41,0x41,0xFF,0xFF,0x0A,0x0A,0xFF,0xFF,0xFF; inj_busy falls after the 8th frame.
- Pre-emption: push 0x42, joy_buttons=0x10 during the first HOLD frame for 3 frames -> frames 0x42,0xEF,0xEF,0xEF,0x42,0xFF,0xFF; no byte lost.
- Full/wrap: push 20 bytes back-to-back with DEPTH=16 -> inj_ready=0 at count 16, 16 bytes accepted. Pops re-open ready. Repeat twice to wrap the pointers; output order is identical to input.
- Flush and reset: flush during HOLD with 5 queued -> next frame 0xFF, fifo_count=0, inj_busy=0. reset_n pulsed mid-shift -> famicom_data=1 within the reset cycle.

Source files
------------

// File: rtl/gigatron_input_arbiter.sv
// gigatron_input_arbiter
// Drives the Gigatron's single Famicom-style serial controller input and
// shares it between the live joystick and a FIFO of injected bytes. Each
// injected byte is shown for HOLD_FRAMES latch frames and is followed by
// GAP_FRAMES idle (0xFF) frames. This gives the ROM one clean keystroke per
// byte. Any joystick activity overrides injection.
//
// Ports
//   clk_sys        system clock, rising edge
//   reset_n        asynchronous active-low reset
//   joy_buttons    active-high NES buttons (bit0 A ... bit7 Right)
//   famicom_latch  latch from the Gigatron (asynchronous)
//   famicom_pulse  shift clock from the Gigatron (asynchronous)
//   famicom_data   serial data to the Gigatron
//   inj_valid      injected byte valid
//   inj_data       injected byte
//   inj_ready      FIFO can accept a byte
//   flush          synchronous abort of all injection
//   inj_busy       FIFO non-empty or sequencer not idle
//   fifo_count     current FIFO occupancy
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no byte presented; pops the FIFO when the joystick is idle
// HOLD  | char_reg presented; counts frames seen while joystick idle
// GAP   | 0xFF presented; counts every frame before the next byte
module gigatron_input_arbiter #(
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_FRAMES = 2,
    parameter int GAP_FRAMES  = 2,
    parameter int CR_TO_LF    = 1
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [7:0]                    joy_buttons,
    input  logic                          famicom_latch,
    input  logic                          famicom_pulse,
    output logic                          famicom_data,
    input  logic                          inj_valid,
    input  logic [7:0]                    inj_data,
    output logic                          inj_ready,
    input  logic                          flush,
    output logic                          inj_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXF = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
    localparam int NW   = $clog2(MAXF + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [NW-1:0] hold_cnt, hold_nx;
    logic [NW-1:0] gap_cnt, gap_nx;
    logic [7:0]    char_reg, char_nx;

    logic          latch_s1, latch_s2, latch_d;
    logic          pulse_s1, pulse_s2, pulse_d;
    logic          frame_evt, pulse_fall;
    logic [7:0]    shift;
    logic [7:0]    sel_val;
    logic          joy_active;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, push, pop;
    logic [7:0]    head;

    // ---------------- synchronizers and edge detect ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            latch_s1 <= 1'b0;
            latch_s2 <= 1'b0;
            latch_d  <= 1'b0;
            pulse_s1 <= 1'b0;
            pulse_s2 <= 1'b0;
            pulse_d  <= 1'b0;
        end else begin
            latch_s1 <= famicom_latch;
            latch_s2 <= latch_s1;
            latch_d  <= latch_s2;
            pulse_s1 <= famicom_pulse;
            pulse_s2 <= pulse_s1;
            pulse_d  <= pulse_s2;
        end
    end

    assign frame_evt  = latch_d & ~latch_s2;
    assign pulse_fall = pulse_d & ~pulse_s2;
    assign joy_active = (joy_buttons != 8'h00);

    always_comb begin
        sel_val = 8'hFF;
        if (joy_active)
            sel_val = ~joy_buttons;
        else if (state == S_HOLD)
            sel_val = char_reg;
    end

    // ---------------- serial shift register ----------------
    // A held latch reloads every cycle, so a pulse edge during latch is ignored.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            shift <= 8'hFF;
        else if (latch_s2)
            shift <= sel_val;
        else if (pulse_fall)
            shift <= {1'b1, shift[7:1]};
    end

    assign famicom_data = shift[0];

    // ---------------- injection FIFO ----------------
    assign empty      = (count == '0);
    assign inj_ready  = (count < CW'(FIFO_DEPTH));
    assign push       = inj_valid && inj_ready && !flush;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr] <= inj_data;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            char_reg <= 8'hFF;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            gap_cnt  <= gap_nx;
            char_reg <= char_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        gap_nx   = gap_cnt;
        char_nx  = char_reg;
        pop      = 1'b0;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty && !joy_active) begin
                        pop      = 1'b1;
                        char_nx  = (CR_TO_LF != 0 && head == 8'h0D) ? 8'h0A : head;
                        hold_nx  = NW'(HOLD_FRAMES);
                        state_nx = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Frames shown while the joystick overrides do not count.
                    if (frame_evt && !joy_active) begin
                        if (hold_cnt == NW'(1)) begin
                            hold_nx  = '0;
                            gap_nx   = NW'(GAP_FRAMES);
                            state_nx = S_GAP;
                        end else begin
                            hold_nx = hold_cnt - NW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (frame_evt) begin
                        if (gap_cnt == NW'(1)) begin
                            gap_nx   = '0;
                            state_nx = S_IDLE;
                        end else begin
                            gap_nx = gap_cnt - NW'(1);
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    assign inj_busy = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_gigatron_input_arbiter.sv
`timescale 1ns/1ps
module tb_gigatron_input_arbiter;

    localparam int DEPTH = 16;
    localparam int HOLD  = 2;
    localparam int GAP   = 2;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] joy_buttons = 8'h00;
    logic       famicom_latch = 1'b0;
    logic       famicom_pulse = 1'b0;
    logic       famicom_data;
    logic       inj_valid = 1'b0;
    logic [7:0] inj_data = 8'h00;
    logic       inj_ready;
    logic       flush = 1'b0;
    logic       inj_busy;
    logic [4:0] fifo_count;

    int errors = 0;
    int checks = 0;

    gigatron_input_arbiter #(
        .FIFO_DEPTH(DEPTH), .HOLD_FRAMES(HOLD), .GAP_FRAMES(GAP), .CR_TO_LF(1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy_buttons(joy_buttons),
        .famicom_latch(famicom_latch), .famicom_pulse(famicom_pulse),
        .famicom_data(famicom_data), .inj_valid(inj_valid), .inj_data(inj_data),
        .inj_ready(inj_ready), .flush(flush), .inj_busy(inj_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    logic [7:0] m_q[$];
    int         m_mode;   // 0 idle, 1 showing byte, 2 idle gap
    int         m_cnt;
    logic [7:0] m_char;

    task automatic model_reset();
        m_q.delete();
        m_mode = 0;
        m_cnt  = 0;
        m_char = 8'hFF;
    endtask

    // Between frames the joystick is released, so a waiting byte is taken.
    task automatic model_pre();
        logic [7:0] b;
        if (m_mode == 0 && m_q.size() > 0) begin
            b      = m_q.pop_front();
            m_char = (b == 8'h0D) ? 8'h0A : b;
            m_mode = 1;
            m_cnt  = HOLD;
        end
    endtask

    task automatic model_frame(input logic [7:0] j, output logic [7:0] e);
        if (j != 8'h00)      e = ~j;
        else if (m_mode == 1) e = m_char;
        else                 e = 8'hFF;
        if (m_mode == 1 && j == 8'h00) begin
            m_cnt--;
            if (m_cnt == 0) begin m_mode = 2; m_cnt = GAP; end
        end else if (m_mode == 2) begin
            m_cnt--;
            if (m_cnt == 0) m_mode = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        inj_valid = 1'b0; flush = 1'b0; joy_buttons = 8'h00;
        famicom_latch = 1'b0; famicom_pulse = 1'b0;
        @(negedge clk_sys); reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        model_reset();
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk_sys);
        inj_data = b; inj_valid = 1'b1;
        @(negedge clk_sys);
        inj_valid = 1'b0;
    endtask

    // One latch + 8 pulses; bits read LSB first, plus the 9th read.
    task automatic do_frame(input logic [7:0] j, output logic [7:0] v, output logic b9);
        joy_buttons = j;
        repeat (2) @(negedge clk_sys);
        famicom_latch = 1'b1;
        repeat (4) @(negedge clk_sys);
        famicom_latch = 1'b0;
        repeat (4) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            v[i] = famicom_data;
            famicom_pulse = 1'b1;
            repeat (3) @(negedge clk_sys);
            famicom_pulse = 1'b0;
            repeat (4) @(negedge clk_sys);
        end
        b9 = famicom_data;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic frame(input logic [7:0] j, output logic [7:0] v, output logic b9);
        joy_buttons = 8'h00;
        repeat (6) @(negedge clk_sys);
        do_frame(j, v, b9);
    endtask

    typedef struct {
        logic [7:0] joy;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[6];

    initial begin
        logic [7:0] v, e;
        logic       b9;
        logic [7:0] exp_seq [9];
        logic [7:0] pj [7];
        logic [7:0] pe [7];
        int         acc;
        logic [7:0] b;

        tbl[0] = '{joy: 8'h01, exp: 8'hFE};
        tbl[1] = '{joy: 8'h10, exp: 8'hEF};
        tbl[2] = '{joy: 8'h80, exp: 8'h7F};
        tbl[3] = '{joy: 8'hFF, exp: 8'h00};
        tbl[4] = '{joy: 8'h5A, exp: 8'hA5};
        tbl[5] = '{joy: 8'h00, exp: 8'hFF};

        // Reset then idle
        do_reset();
        check("reset_data", int'(famicom_data), 1);
        check("reset_ready", int'(inj_ready), 1);
        check("reset_busy", int'(inj_busy), 0);
        check("reset_count", int'(fifo_count), 0);
        for (int f = 0; f < 5; f++) begin
            frame(8'h00, v, b9);
            check("idle_frame", int'(v), 8'hFF);
        end
        check("idle_ready", int'(inj_ready), 1);
        check("idle_count", int'(fifo_count), 0);

        // Joystick table
        for (int i = 0; i < 6; i++) begin
            frame(tbl[i].joy, v, b9);
            check("joy_frame", int'(v), int'(tbl[i].exp));
            check("joy_bit9", int'(b9), 1);
        end

        // Injection timing with CR translation
        do_reset();
        exp_seq = '{8'h41, 8'h41, 8'hFF, 8'hFF, 8'h0A, 8'h0A, 8'hFF, 8'hFF, 8'hFF};
        push_byte(8'h41);
        push_byte(8'h0D);
        for (int i = 0; i < 9; i++) begin
            frame(8'h00, v, b9);
            check("inject_frame", int'(v), int'(exp_seq[i]));
            if (i == 6) check("inject_busy_f7", int'(inj_busy), 1);
            if (i == 7) check("inject_busy_f8", int'(inj_busy), 0);
        end

        // Joystick pre-emption freezes the held byte
        do_reset();
        pj = '{8'h00, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00};
        pe = '{8'h42, 8'hEF, 8'hEF, 8'hEF, 8'h42, 8'hFF, 8'hFF};
        push_byte(8'h42);
        for (int i = 0; i < 7; i++) begin
            frame(pj[i], v, b9);
            check("preempt_frame", int'(v), int'(pe[i]));
        end
        check("preempt_busy", int'(inj_busy), 0);

        // Full / wrap: joystick held so nothing pops during the burst
        do_reset();
        for (int r = 0; r < 2; r++) begin
            joy_buttons = 8'h01;
            acc = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_sys);
                b = 8'(r * 37 + i * 5 + 3);
                inj_data = b; inj_valid = 1'b1;
                if (inj_ready) acc++;
                if (i < DEPTH) m_q.push_back(b);
            end
            @(negedge clk_sys);
            inj_valid = 1'b0;
            check("full_accepted", acc, DEPTH);
            check("full_count", int'(fifo_count), DEPTH);
            check("full_ready", int'(inj_ready), 0);
            joy_buttons = 8'h00;
            repeat (3) @(negedge clk_sys);
            model_pre();
            check("reopen_ready", int'(inj_ready), 1);
            check("reopen_count", int'(fifo_count), DEPTH - 1);
            for (int f = 0; f < DEPTH * (HOLD + GAP); f++) begin
                joy_buttons = 8'h00;
                repeat (6) @(negedge clk_sys);
                model_pre();
                do_frame(8'h00, v, b9);
                model_frame(8'h00, e);
                check("drain_frame", int'(v), int'(e));
            end
            check("drain_busy", int'(inj_busy), 0);
            check("drain_count", int'(fifo_count), 0);
        end

        // Flush during HOLD with 5 queued; push in the flush cycle is blocked
        do_reset();
        for (int i = 0; i < 6; i++) push_byte(8'(8'h31 + i));
        repeat (2) @(negedge clk_sys);
        check("flush_pre_count", int'(fifo_count), 5);
        frame(8'h00, v, b9);
        check("flush_pre_frame", int'(v), 8'h31);
        @(negedge clk_sys);
        flush = 1'b1; inj_valid = 1'b1; inj_data = 8'h55;
        @(negedge clk_sys);
        flush = 1'b0; inj_valid = 1'b0;
        check("flush_count", int'(fifo_count), 0);
        check("flush_busy", int'(inj_busy), 0);
        check("flush_ready", int'(inj_ready), 1);
        frame(8'h00, v, b9);
        check("flush_next_frame", int'(v), 8'hFF);
        check("flush_after_busy", int'(inj_busy), 0);

        // Reset mid-shift forces data high asynchronously
        do_reset();
        joy_buttons = 8'h01;
        repeat (2) @(negedge clk_sys);
        famicom_latch = 1'b1;
        repeat (4) @(negedge clk_sys);
        famicom_latch = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("midreset_bit0", int'(famicom_data), 0);
        famicom_pulse = 1'b1;
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1 check("midreset_data", int'(famicom_data), 1);
        famicom_pulse = 1'b0;
        joy_buttons = 8'h00;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("midreset_after", int'(famicom_data), 1);

        // Randomized frames against the frame-level model
        do_reset();
        for (int f = 0; f < 60; f++) begin
            joy_buttons = 8'h00;
            if (m_q.size() < 6) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    case ($urandom_range(0, 5))
                        0:       b = 8'h0D;
                        1:       b = 8'hFF;
                        default: b = 8'($urandom);
                    endcase
                    check("rand_ready", int'(inj_ready), 1);
                    push_byte(b);
                    m_q.push_back(b);
                end
            end
            repeat (6) @(negedge clk_sys);
            model_pre();
            check("rand_count", int'(fifo_count), m_q.size());
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            do_frame(b, v, b9);
            model_frame(b, e);
            check("rand_frame", int'(v), int'(e));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
